// File: rtl/fc_pkg.sv
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared FC-layer defaults, writer state and word types, and
//                the ReLU clamp used by the FC datapath and result writer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fc_pkg;

    localparam int unsigned FC_WORD_SIZE     = 16;
    localparam int unsigned FC_OP_LAYER_SIZE = 84;
    localparam int unsigned FC_ADDRESS_SIZE  = 16;
    localparam int unsigned FC_MAX_WORD      = 64;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_WRITE = 2'd1,
        WR_DONE  = 2'd2
    } wr_state_e;

    typedef logic signed [FC_WORD_SIZE-1:0] word_t;

    // Width-agnostic clamp: caller zero-extends the word and supplies its sign bit.
    function automatic logic [FC_MAX_WORD-1:0] fc_relu(input logic [FC_MAX_WORD-1:0] w,
                                                       input logic                   neg);
        return neg ? '0 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fc_result_writer_if.sv
// ============================================================================
//  Module      : fc_result_writer_if
//  Description : RAM write channel (valid/ready) between result writer and RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fc_result_writer_if #(
    parameter int WORD_SIZE    = fc_pkg::FC_WORD_SIZE,
    parameter int ADDRESS_SIZE = fc_pkg::FC_ADDRESS_SIZE
);
    logic                    ram_wr_en;
    logic [ADDRESS_SIZE-1:0] ram_addr;
    logic [WORD_SIZE-1:0]    ram_data;
    logic                    ram_wr_ready;

    modport master (
        output ram_wr_en,
        output ram_addr,
        output ram_data,
        input  ram_wr_ready
    );

    modport slave (
        input  ram_wr_en,
        input  ram_addr,
        input  ram_data,
        output ram_wr_ready
    );
endinterface

`default_nettype wire

// File: rtl/fc_result_writer.sv
// ============================================================================
//  Module      : fc_result_writer
//  Description : Snapshots an FC output vector on start and streams it word by
//                word to RAM over a valid/ready channel. Optional macro
//                FC_WR_RELU_EN clamps negative words to zero on write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fc_result_writer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE     = FC_WORD_SIZE,
    parameter int OP_LAYER_SIZE = FC_OP_LAYER_SIZE,
    parameter int ADDRESS_SIZE  = FC_ADDRESS_SIZE
) (
    input  wire logic                                 clk,
    input  wire logic                                 reset,
    input  wire logic                                 start,
    input  wire logic [ADDRESS_SIZE-1:0]              base_addr,
    input  wire logic [WORD_SIZE*OP_LAYER_SIZE-1:0]   Y,
    output logic                                      busy,
    output logic                                      done,
    fc_result_writer_if.master                        ram
);

    localparam int IDX_W = (OP_LAYER_SIZE > 1) ? $clog2(OP_LAYER_SIZE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(OP_LAYER_SIZE - 1);

    wr_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q;
    logic [ADDRESS_SIZE-1:0] base_q;
    logic [WORD_SIZE-1:0]    shadow_q [OP_LAYER_SIZE];

    logic                    w_accept;
    logic                    w_fire;
    logic [WORD_SIZE-1:0]    w_word;
    logic [WORD_SIZE-1:0]    w_data;

    assign w_accept = (state_q == WR_IDLE) && start;
    assign w_fire   = (state_q == WR_WRITE) && ram.ram_wr_ready;
    assign w_word   = shadow_q[idx_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WR_IDLE:  if (start) state_d = WR_WRITE;
            WR_WRITE: if (ram.ram_wr_ready && (idx_q == C_LAST_IDX)) state_d = WR_DONE;
            WR_DONE:  state_d = WR_IDLE;
            default:  state_d = WR_IDLE;
        endcase
    end

    // Snapshot is taken only in IDLE so a running transfer is immune to input changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            base_q <= '0;
            for (int i = 0; i < OP_LAYER_SIZE; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (w_accept) begin
            idx_q  <= '0;
            base_q <= base_addr;
            for (int i = 0; i < OP_LAYER_SIZE; i++) begin
                shadow_q[i] <= Y[i*WORD_SIZE +: WORD_SIZE];
            end
        end else if (w_fire) begin
            idx_q <= (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef FC_WR_RELU_EN
    logic [FC_MAX_WORD-1:0] w_ext;
    logic [FC_MAX_WORD-1:0] w_clamped;

    always_comb begin
        w_ext                = '0;
        w_ext[WORD_SIZE-1:0] = w_word;
    end

    assign w_clamped = fc_relu(w_ext, w_word[WORD_SIZE-1]);
    assign w_data    = w_clamped[WORD_SIZE-1:0];
`else
    assign w_data = w_word;
`endif

    always_comb begin
        ram.ram_wr_en = 1'b0;
        ram.ram_addr  = '0;
        ram.ram_data  = '0;
        if (state_q == WR_WRITE) begin
            ram.ram_wr_en = 1'b1;
            ram.ram_addr  = base_q + ADDRESS_SIZE'(idx_q);
            ram.ram_data  = w_data;
        end
    end

    assign busy = (state_q != WR_IDLE);
    assign done = (state_q == WR_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fc_result_writer.sv
// ============================================================================
//  Module      : tb_fc_result_writer
//  Description : Self-checking bench for fc_result_writer against a vector
//                snapshot model (expected address/data list built at start).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fc_result_writer;

    localparam int WS = 16;
    localparam int N  = 84;
    localparam int AS = 16;

    logic            clk;
    logic            reset;
    logic            start;
    logic [AS-1:0]   base_addr;
    logic [WS*N-1:0] Y;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [WS-1:0] ymem [N];
    bit            check_w5;

    fc_result_writer_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) ram_if ();

    fc_result_writer #(
        .WORD_SIZE    (WS),
        .OP_LAYER_SIZE(N),
        .ADDRESS_SIZE (AS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .Y        (Y),
        .busy     (busy),
        .done     (done),
        .ram      (ram_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WS-1:0] ref_word(input logic [WS-1:0] y);
`ifdef FC_WR_RELU_EN
        return ($signed(y) < 0) ? '0 : y;
`else
        return y;
`endif
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, 32'(ram_if.ram_wr_en), 32'd0);
        chk({tag, "_addr"},  32'(ram_if.ram_addr),  32'd0);
        chk({tag, "_data"},  32'(ram_if.ram_data),  32'd0);
        chk({tag, "_busy"},  32'(busy),             32'd0);
        chk({tag, "_done"},  32'(done),             32'd0);
    endtask

    // mode: 0 = ready always high, 1 = ready 1-of-3 cycles, 2 = random ready.
    // abort_at >= 0 asserts reset once that many words have been accepted.
    task automatic run_xfer(input logic [AS-1:0] base, input int mode,
                            input bit disturb, input int abort_at);
        logic [WS-1:0] ed [N];
        logic [AS-1:0] ea;
        int            k;
        int            cyc;
        int            busy_n;
        bit            fired;

        for (int i = 0; i < N; i++) ed[i] = ref_word(ymem[i]);

        @(negedge clk);
        for (int i = 0; i < N; i++) Y[i*WS +: WS] = ymem[i];
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) Y[i*WS +: WS] = WS'($urandom);
        base_addr = AS'($urandom);

        k = 0; cyc = 0; busy_n = 0; fired = 1'b0;
        while (k < N && cyc < 3000) begin
            case (mode)
                0:       ram_if.ram_wr_ready = 1'b1;
                1:       ram_if.ram_wr_ready = (cyc % 3 == 0);
                default: ram_if.ram_wr_ready = 1'($urandom_range(0, 1));
            endcase
            if (disturb && k == 40 && !fired) begin
                start     = 1'b1;
                base_addr = AS'($urandom);
                for (int i = 0; i < N; i++) Y[i*WS +: WS] = WS'($urandom);
                fired     = 1'b1;
            end else begin
                start = 1'b0;
            end

            ea = base + AS'(k);
            chk("wr_en", 32'(ram_if.ram_wr_en), 32'd1);
            chk("busy",  32'(busy),             32'd1);
            chk("done",  32'(done),             32'd0);
            chk("addr",  32'(ram_if.ram_addr),  32'(ea));
            chk("data",  32'(ram_if.ram_data),  32'(ed[k]));
            if (check_w5 && k == 5) begin
`ifdef FC_WR_RELU_EN
                chk("word5", 32'(ram_if.ram_data), 32'h0000);
`else
                chk("word5", 32'(ram_if.ram_data), 32'h8003);
`endif
            end
            busy_n++;

            if (abort_at >= 0 && k == abort_at) begin
                reset = 1'b0;
                #1;
                chk_idle_outputs("abort_now");
                repeat (3) begin
                    @(negedge clk);
                    chk_idle_outputs("abort_hold");
                end
                reset = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("post_abort_wr_en", 32'(ram_if.ram_wr_en), 32'd0);
                    chk("post_abort_done",  32'(done),             32'd0);
                end
                return;
            end

            if (ram_if.ram_wr_ready) k++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= 3000) chk("timeout_words", 32'(k), 32'(N));

        ram_if.ram_wr_ready = 1'b1;
        chk("done_pulse",  32'(done),             32'd1);
        chk("done_busy",   32'(busy),             32'd1);
        chk("done_wr_en",  32'(ram_if.ram_wr_en), 32'd0);
        chk("done_addr",   32'(ram_if.ram_addr),  32'd0);
        chk("done_data",   32'(ram_if.ram_data),  32'd0);
        busy_n++;
        if (mode == 0) chk("busy_len", 32'(busy_n), 32'(N + 1));
        @(negedge clk);
        chk_idle_outputs("after_done");
    endtask

    initial begin
        reset               = 1'b0;
        start               = 1'b0;
        base_addr           = '0;
        Y                   = '0;
        ram_if.ram_wr_ready = 1'b0;
        check_w5            = 1'b0;

        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b1;
        @(negedge clk);
        chk_idle_outputs("idle");

        for (int i = 0; i < N; i++) ymem[i] = WS'(i + 1);
        run_xfer(16'h0100, 0, 1'b0, -1);
        run_xfer(16'h0100, 1, 1'b0, -1);

        for (int i = 0; i < N; i++) ymem[i] = WS'($urandom);
        run_xfer(16'hFFFE, 2, 1'b0, -1);

        for (int i = 0; i < N; i++) ymem[i] = WS'($urandom);
        run_xfer(16'h3000, 0, 1'b1, -1);

        for (int i = 0; i < N; i++) ymem[i] = WS'($urandom);
        run_xfer(16'h0400, 2, 1'b0, 10);
        for (int i = 0; i < N; i++) ymem[i] = WS'($urandom);
        run_xfer(16'h0200, 0, 1'b0, -1);

        for (int i = 0; i < N; i++) ymem[i] = WS'(i + 1);
        ymem[5]  = 16'h8003;
        check_w5 = 1'b1;
        run_xfer(16'h0010, 0, 1'b0, -1);
        check_w5 = 1'b0;

        repeat (3) begin
            for (int i = 0; i < N; i++) ymem[i] = WS'($urandom);
            run_xfer(AS'($urandom), 2, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
